// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter using shift-add-3 (double dabble).
// One bit per clock; digits are registered and only updated when a conversion completes.
module bin2bcd_seq #(
    parameter int unsigned BIN_W  = 14,
    parameter int unsigned DIGITS = 4
) (
    input  logic             clock,
    input  logic             rst_n,
    input  logic             start,
    input  logic [BIN_W-1:0] bin_in,
    output logic             busy,
    output logic             done,
    output logic             overflow,
    output logic [3:0]       x1,
    output logic [3:0]       x2,
    output logic [3:0]       x3,
    output logic [3:0]       x4
);

    localparam int unsigned BcdW = 4 * DIGITS;
    localparam int unsigned CntW = $clog2(BIN_W + 1);
    localparam logic [BIN_W-1:0] MaxVal = BIN_W'(9999);

    typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

    state_e            state_q, state_d;
    logic [BIN_W-1:0]  bin_q;
    logic [BcdW-1:0]   bcd_q;
    logic [CntW-1:0]   cnt_q;
    logic              ovf_q;

    logic [BcdW-1:0]   bcd_adj;
    logic [BcdW-1:0]   bcd_shift;
    logic [BIN_W-1:0]  bin_shift;
    logic              last_iter;

    // Add-3 on every nibble >= 5, nibbles independent (no inter-nibble carry).
    always_comb begin
        bcd_adj = bcd_q;
        for (int i = 0; i < int'(DIGITS); i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) begin
                bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
            end
        end
    end

    assign bcd_shift = {bcd_adj[BcdW-2:0], bin_q[BIN_W-1]};
    assign bin_shift = {bin_q[BIN_W-2:0], 1'b0};
    assign last_iter = (cnt_q == CntW'(1));

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (start) state_d = StShift;
            StShift: if (last_iter) state_d = StDone;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        busy = (state_q == StShift);
        done = (state_q == StDone);
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            bin_q    <= '0;
            bcd_q    <= '0;
            cnt_q    <= '0;
            ovf_q    <= 1'b0;
            overflow <= 1'b0;
            x1       <= 4'd0;
            x2       <= 4'd0;
            x3       <= 4'd0;
            x4       <= 4'd0;
        end else begin
            if (state_q == StIdle && start) begin
                bin_q <= bin_in;
                bcd_q <= '0;
                cnt_q <= CntW'(BIN_W);
                ovf_q <= (bin_in > MaxVal);
            end else if (state_q == StShift) begin
                bin_q <= bin_shift;
                bcd_q <= bcd_shift;
                cnt_q <= cnt_q - CntW'(1);
                // Digits are published on the edge that enters DONE, using the final shift.
                if (last_iter) begin
                    overflow <= ovf_q;
                    if (ovf_q) begin
                        x1 <= 4'd9;
                        x2 <= 4'd9;
                        x3 <= 4'd9;
                        x4 <= 4'd9;
                    end else begin
                        x1 <= bcd_shift[3:0];
                        x2 <= bcd_shift[7:4];
                        x3 <= bcd_shift[11:8];
                        x4 <= bcd_shift[15:12];
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Self-checking bench for bin2bcd_seq: scoreboard of expected digits popped on each done pulse,
// plus per-scenario timing and handshake checks.
module tb_bin2bcd_seq;

    logic        clock;
    logic        rst_n;
    logic        start;
    logic [13:0] bin_in;
    logic        busy;
    logic        done;
    logic        overflow;
    logic [3:0]  x1, x2, x3, x4;

    typedef struct packed {
        logic [3:0] d4;
        logic [3:0] d3;
        logic [3:0] d2;
        logic [3:0] d1;
        logic       ovf;
    } exp_t;

    exp_t        sb[$];
    exp_t        e_mon;
    int          checks = 0;
    int          errors = 0;
    int          done_cnt = 0;
    logic        prev_rst = 1'b0;
    logic [16:0] prev_out = '0;

    bin2bcd_seq #(.BIN_W(14), .DIGITS(4)) dut (
        .clock    (clock),
        .rst_n    (rst_n),
        .start    (start),
        .bin_in   (bin_in),
        .busy     (busy),
        .done     (done),
        .overflow (overflow),
        .x1       (x1),
        .x2       (x2),
        .x3       (x3),
        .x4       (x4)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic exp_t model(input int v);
        exp_t e;
        if (v > 9999) begin
            e = '{d4: 4'd9, d3: 4'd9, d2: 4'd9, d1: 4'd9, ovf: 1'b1};
        end else begin
            e.d1  = 4'(v % 10);
            e.d2  = 4'((v / 10) % 10);
            e.d3  = 4'((v / 100) % 10);
            e.d4  = 4'((v / 1000) % 10);
            e.ovf = 1'b0;
        end
        return e;
    endfunction

    // Output monitor: compare digits on every done pulse; digits must hold otherwise.
    always @(negedge clock) begin
        if (rst_n && done) begin
            done_cnt = done_cnt + 1;
            checks = checks + 1;
            if (sb.size() == 0) begin
                errors = errors + 1;
                $display("FAIL done_unexpected: done pulse with empty scoreboard, x=%0d%0d%0d%0d",
                         x4, x3, x2, x1);
            end else begin
                e_mon = sb.pop_front();
                if ({x4, x3, x2, x1, overflow} !== e_mon) begin
                    errors = errors + 1;
                    $display("FAIL result: got x4..x1=%0d,%0d,%0d,%0d ovf=%0b want %0d,%0d,%0d,%0d ovf=%0b",
                             x4, x3, x2, x1, overflow, e_mon.d4, e_mon.d3, e_mon.d2, e_mon.d1,
                             e_mon.ovf);
                end
            end
        end
        if (rst_n && prev_rst && !done) begin
            checks = checks + 1;
            if ({x4, x3, x2, x1, overflow} !== prev_out) begin
                errors = errors + 1;
                $display("FAIL hold: outputs changed outside done, got %h want %h",
                         {x4, x3, x2, x1, overflow}, prev_out);
            end
        end
        prev_out = {x4, x3, x2, x1, overflow};
        prev_rst = rst_n;
    end

    task automatic launch(input int v, input bit push);
        start  = 1'b1;
        bin_in = 14'(v);
        if (push) sb.push_back(model(v));
        @(negedge clock);
        start  = 1'b0;
    endtask

    // Called in cycle 1 after the accepting edge; returns the cycle index where done was seen.
    task automatic wait_done(output int cyc, output int bcyc);
        cyc  = 1;
        bcyc = 0;
        while (!done && cyc < 40) begin
            if (busy) bcyc++;
            @(negedge clock);
            cyc++;
        end
    endtask

    task automatic test_reset();
        rst_n  = 1'b0;
        start  = 1'b0;
        bin_in = '0;
        repeat (3) @(negedge clock);
        checks = checks + 1;
        if ({busy, done, overflow, x4, x3, x2, x1} !== 19'd0) begin
            errors = errors + 1;
            $display("FAIL reset_state: got %h want 0", {busy, done, overflow, x4, x3, x2, x1});
        end
        #2 rst_n = 1'b1;
        repeat (2) @(negedge clock);
        checks = checks + 1;
        if ({busy, done} !== 2'b00) begin
            errors = errors + 1;
            $display("FAIL idle_after_reset: busy/done=%b want 00", {busy, done});
        end
    endtask

    task automatic test_zero();
        int cyc, bcyc;
        launch(0, 1'b1);
        wait_done(cyc, bcyc);
        checks = checks + 1;
        if (cyc !== 15 || done !== 1'b1) begin
            errors = errors + 1;
            $display("FAIL zero_latency: done at cycle %0d (done=%b) want 15", cyc, done);
        end
        @(negedge clock);
    endtask

    task automatic test_1234();
        int cyc, bcyc;
        launch(1234, 1'b1);
        wait_done(cyc, bcyc);
        checks = checks + 1;
        if (bcyc !== 14) begin
            errors = errors + 1;
            $display("FAIL busy_len: busy %0d cycles want 14", bcyc);
        end
        checks = checks + 1;
        if (cyc !== 15 || busy !== 1'b0) begin
            errors = errors + 1;
            $display("FAIL done_timing: done cycle %0d busy=%b want 15 busy=0", cyc, busy);
        end
        @(negedge clock);
        checks = checks + 1;
        if ({busy, done} !== 2'b00) begin
            errors = errors + 1;
            $display("FAIL done_pulse: after done busy/done=%b want 00", {busy, done});
        end
    endtask

    task automatic test_back_to_back();
        int cyc, bcyc, d0;
        d0 = done_cnt;
        launch(9999, 1'b1);
        wait_done(cyc, bcyc);
        @(negedge clock);
        launch(5, 1'b1);
        wait_done(cyc, bcyc);
        checks = checks + 1;
        if (cyc !== 15) begin
            errors = errors + 1;
            $display("FAIL b2b_latency: second done at cycle %0d want 15", cyc);
        end
        @(negedge clock);
        checks = checks + 1;
        if (done_cnt - d0 !== 2) begin
            errors = errors + 1;
            $display("FAIL b2b_pulses: %0d done pulses want 2", done_cnt - d0);
        end
    endtask

    task automatic test_overflow();
        int cyc, bcyc;
        launch(12000, 1'b1);
        wait_done(cyc, bcyc);
        checks = checks + 1;
        if (overflow !== 1'b1) begin
            errors = errors + 1;
            $display("FAIL ovf_flag: overflow=%b want 1", overflow);
        end
        repeat (2) @(negedge clock);
        launch(42, 1'b1);
        wait_done(cyc, bcyc);
        checks = checks + 1;
        if (overflow !== 1'b0) begin
            errors = errors + 1;
            $display("FAIL ovf_clear: overflow=%b want 0", overflow);
        end
        @(negedge clock);
    endtask

    task automatic test_ignore();
        int cyc, bcyc, d0;
        d0 = done_cnt;
        launch(77, 1'b1);
        repeat (4) @(negedge clock);
        launch(3000, 1'b0);
        wait_done(cyc, bcyc);
        checks = checks + 1;
        if (done !== 1'b1) begin
            errors = errors + 1;
            $display("FAIL ignore_timeout: no done seen, done=%b want 1", done);
        end
        repeat (25) @(negedge clock);
        checks = checks + 1;
        if (done_cnt - d0 !== 1 || busy !== 1'b0) begin
            errors = errors + 1;
            $display("FAIL ignore_pulses: %0d pulses busy=%b want 1 busy=0", done_cnt - d0, busy);
        end
    endtask

    task automatic test_reset_abort();
        int cyc, bcyc, d0;
        d0 = done_cnt;
        launch(8765, 1'b0);
        repeat (6) @(negedge clock);
        #2 rst_n = 1'b0;
        #1;
        checks = checks + 1;
        if ({busy, done, overflow, x4, x3, x2, x1} !== 19'd0) begin
            errors = errors + 1;
            $display("FAIL abort_state: got %h want 0", {busy, done, overflow, x4, x3, x2, x1});
        end
        @(negedge clock);
        #2 rst_n = 1'b1;
        repeat (20) @(negedge clock);
        checks = checks + 1;
        if (done_cnt !== d0 || busy !== 1'b0) begin
            errors = errors + 1;
            $display("FAIL abort_no_done: %0d pulses busy=%b want 0 busy=0", done_cnt - d0, busy);
        end
        launch(8765, 1'b1);
        wait_done(cyc, bcyc);
        checks = checks + 1;
        if (cyc !== 15) begin
            errors = errors + 1;
            $display("FAIL retry_latency: done at cycle %0d want 15", cyc);
        end
        repeat (2) @(negedge clock);
    endtask

    initial begin
        test_reset();
        test_zero();
        test_1234();
        test_back_to_back();
        test_overflow();
        test_ignore();
        test_reset_abort();
        checks = checks + 1;
        if (sb.size() !== 0) begin
            errors = errors + 1;
            $display("FAIL scoreboard_drain: %0d results outstanding want 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
